multicycle_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the MIPS core: issues per-cycle control strobes for FETCH/DECODE/EXEC/MEM/WB.
- Sequence length depends on the decoded instruction class.
- Stalls on a memory wait-request handshake and traps on stalled-bus timeout.
- Counts retired instructions.
- Sits between the instruction decoder (supplies `instr_class`) and the datapath/memory interface (consumes the strobes).

---
 rtl/multicycle_sequencer.sv | 150 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the MIPS core: walks FETCH/DECODE/EXEC/MEM/WB,
// decodes per-cycle datapath strobes, traps bus stalls and counts retired instructions.
module multicycle_sequencer #(
  parameter int STALL_LIMIT = 16,
  parameter int WAIT_W      = 8,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [2:0]       i_instr_class,
  input  logic             i_waitrequest,
  output logic             o_pc_inc,
  output logic             o_ir_write,
  output logic             o_alu_en,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_addr_sel,
  output logic             o_reg_write,
  output logic             o_active,
  output logic             o_timeout_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [2:0] C_ALU   = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_STORE = 3'd2;
  localparam logic [2:0] C_HALT  = 3'd4;

  state_t             r_state;
  logic [2:0]         r_class;
  logic [WAIT_W-1:0]  r_stall;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_retired;

  state_t w_next;
  logic   w_stall_hit;
  logic   w_pc_inc, w_ir_write, w_alu_en, w_mem_read, w_mem_write;
  logic   w_addr_sel, w_reg_write, w_active;

  // The stall that would be the STALL_LIMIT-th consecutive one traps instead of holding.
  assign w_stall_hit = (STALL_LIMIT != 0) && (r_stall == WAIT_W'(STALL_LIMIT - 1));

  always_comb begin
    w_next      = r_state;
    w_pc_inc    = 1'b0;
    w_ir_write  = 1'b0;
    w_alu_en    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_addr_sel  = 1'b0;
    w_reg_write = 1'b0;
    w_active    = (r_state != S_HALTED) && (r_state != S_ERROR);
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (i_waitrequest) begin
          if (w_stall_hit) w_next = S_ERROR;
        end else begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_alu_en = 1'b1;
        case (i_instr_class)
          C_ALU:          w_next = S_WB;
          C_LOAD, C_STORE: w_next = S_MEM;
          C_HALT: begin
            w_pc_inc = 1'b1;
            w_next   = S_HALTED;
          end
          default: begin
            // Branch/jump and reserved classes: retire without touching regs or memory.
            w_pc_inc = 1'b1;
            w_next   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        w_addr_sel = 1'b1;
        if (r_class == C_LOAD) w_mem_read  = 1'b1;
        else                   w_mem_write = 1'b1;
        if (i_waitrequest) begin
          if (w_stall_hit) w_next = S_ERROR;
        end else if (r_class == C_LOAD) begin
          w_next = S_WB;
        end else begin
          w_pc_inc = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_inc    = 1'b1;
        w_next      = S_FETCH;
      end
      S_HALTED, S_ERROR: w_next = r_state;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_FETCH;
      r_class   <= C_ALU;
      r_stall   <= '0;
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_stall <= '0;
      else if (((r_state == S_FETCH) || (r_state == S_MEM)) && i_waitrequest)
        r_stall <= r_stall + 1'b1;
      if ((w_next == S_ERROR) && (r_state != S_ERROR))
        r_timeout <= 1'b1;
      if (r_state == S_EXEC)
        r_class <= i_instr_class;
      if (w_pc_inc)
        r_retired <= r_retired + 1'b1;
    end
  end

  // Reset gates every strobe so an access in flight is dropped on the reset cycle itself.
  assign o_pc_inc      = i_reset_n & w_pc_inc;
  assign o_ir_write    = i_reset_n & w_ir_write;
  assign o_alu_en      = i_reset_n & w_alu_en;
  assign o_mem_read    = i_reset_n & w_mem_read;
  assign o_mem_write   = i_reset_n & w_mem_write;
  assign o_addr_sel    = i_reset_n & w_addr_sel;
  assign o_reg_write   = i_reset_n & w_reg_write;
  assign o_active      = i_reset_n & w_active;
  assign o_timeout_err = r_timeout;
  assign o_state       = r_state;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench: instruction-level plans expand into expected per-cycle traces, replayed on two
// configurations (default, and STALL_LIMIT=4/CNT_W=4).
module tb_multicycle_sequencer;

  localparam logic [7:0] PC  = 8'h80;
  localparam logic [7:0] IR  = 8'h40;
  localparam logic [7:0] ALU = 8'h20;
  localparam logic [7:0] MR  = 8'h10;
  localparam logic [7:0] MW  = 8'h08;
  localparam logic [7:0] AS  = 8'h04;
  localparam logic [7:0] RW  = 8'h02;
  localparam logic [7:0] ACT = 8'h01;

  typedef struct {
    bit          rst;
    bit          chk;
    logic [2:0]  st;
    logic        w;
    logic [2:0]  cls;
    logic [7:0]  strb;
    logic        to;
    logic [31:0] ret;
  } ent_t;

  logic clk;
  logic rst_n, wreq, sel;
  logic [2:0] icls;

  logic a_pc, a_ir, a_alu, a_mr, a_mw, a_as, a_rw, a_act, a_to;
  logic [2:0] a_st;
  logic [31:0] a_ret;
  logic b_pc, b_ir, b_alu, b_mr, b_mw, b_as, b_rw, b_act, b_to;
  logic [2:0] b_st;
  logic [3:0] b_ret;

  logic [7:0]  obs_strb;
  logic [2:0]  obs_st;
  logic        obs_to;
  logic [31:0] obs_ret;

  ent_t        tq[$];
  logic [31:0] m_ret, m_mask;
  logic        m_to;
  int          m_lim;
  int          n_chk, n_pass;

  multicycle_sequencer dut_a (
    .i_clk(clk), .i_reset_n(rst_n & ~sel), .i_instr_class(icls), .i_waitrequest(wreq),
    .o_pc_inc(a_pc), .o_ir_write(a_ir), .o_alu_en(a_alu), .o_mem_read(a_mr),
    .o_mem_write(a_mw), .o_addr_sel(a_as), .o_reg_write(a_rw), .o_active(a_act),
    .o_timeout_err(a_to), .o_state(a_st), .o_retired(a_ret)
  );

  multicycle_sequencer #(.STALL_LIMIT(4), .WAIT_W(8), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n & sel), .i_instr_class(icls), .i_waitrequest(wreq),
    .o_pc_inc(b_pc), .o_ir_write(b_ir), .o_alu_en(b_alu), .o_mem_read(b_mr),
    .o_mem_write(b_mw), .o_addr_sel(b_as), .o_reg_write(b_rw), .o_active(b_act),
    .o_timeout_err(b_to), .o_state(b_st), .o_retired(b_ret)
  );

  always_comb begin
    if (sel) begin
      obs_strb = {b_pc, b_ir, b_alu, b_mr, b_mw, b_as, b_rw, b_act};
      obs_st   = b_st;
      obs_to   = b_to;
      obs_ret  = {28'd0, b_ret};
    end else begin
      obs_strb = {a_pc, a_ir, a_alu, a_mr, a_mw, a_as, a_rw, a_act};
      obs_st   = a_st;
      obs_to   = a_to;
      obs_ret  = a_ret;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s check#%0d got=%h expected=%h", tag, n_chk, got, exp);
  endtask

  function automatic logic rw();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rc();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input bit rst, input bit c, input logic [2:0] st, input logic w,
                      input logic [2:0] cls, input logic [7:0] strb);
    ent_t e;
    e.rst = rst; e.chk = c; e.st = st; e.w = w; e.cls = cls; e.strb = strb;
    e.to = m_to; e.ret = m_ret;
    tq.push_back(e);
    if (rst) begin
      m_ret = 0;
      m_to  = 1'b0;
    end else if (strb[7]) begin
      m_ret = (m_ret + 1) & m_mask;
    end
  endtask

  task automatic push_err();
    m_to = 1'b1;
    for (int i = 0; i < 5; i++) push(0, 1, 3'd6, rw(), rc(), 8'h00);
  endtask

  // One instruction: fw FETCH wait cycles, mw MEM wait cycles; abort = reset after the MEM waits.
  task automatic push_instr(input int cls, input int fw, input int mw, input bit abort,
                            output bit stop);
    logic [7:0] mb, pcb;
    stop = 1'b0;
    for (int k = 0; k < fw; k++) begin
      push(0, 1, 3'd0, 1'b1, rc(), MR | ACT);
      if (m_lim != 0 && k == m_lim - 1) begin push_err(); stop = 1'b1; return; end
    end
    push(0, 1, 3'd0, 1'b0, rc(), MR | IR | ACT);
    push(0, 1, 3'd1, rw(), rc(), ACT);
    pcb = (cls >= 3) ? PC : 8'h00;
    push(0, 1, 3'd2, rw(), 3'(cls), ALU | ACT | pcb);
    if (cls == 4) begin
      for (int i = 0; i < 20; i++) push(0, 1, 3'd5, rw(), rc(), 8'h00);
      stop = 1'b1;
      return;
    end
    if (cls >= 3) return;
    if (cls != 0) begin
      mb = (cls == 1) ? MR : MW;
      for (int k = 0; k < mw; k++) begin
        push(0, 1, 3'd3, 1'b1, rc(), mb | AS | ACT);
        if (!abort && m_lim != 0 && k == m_lim - 1) begin push_err(); stop = 1'b1; return; end
      end
      if (abort) begin push(1, 1, 3'd3, 1'b1, rc(), 8'h00); return; end
      pcb = (cls == 2) ? PC : 8'h00;
      push(0, 1, 3'd3, 1'b0, rc(), mb | AS | ACT | pcb);
      if (cls == 2) return;
    end
    push(0, 1, 3'd4, rw(), rc(), RW | PC | ACT);
  endtask

  task automatic push_random(input int n, input int fmax, input int mmax);
    bit s;
    int c, fw;
    for (int i = 0; i < n; i++) begin
      c = $urandom_range(0, 6);
      if (c >= 4) c++;
      fw = $urandom_range(0, fmax);
      push_instr(c, fw, $urandom_range(0, mmax), 1'b0, s);
    end
  endtask

  task automatic run_trace();
    ent_t e;
    while (tq.size() > 0) begin
      e = tq.pop_front();
      rst_n = ~e.rst;
      wreq  = e.w;
      icls  = e.cls;
      @(negedge clk);
      chk("strobes", {24'd0, obs_strb}, {24'd0, e.strb});
      if (e.chk) begin
        chk("state", {29'd0, obs_st}, {29'd0, e.st});
        chk("timeout_err", {31'd0, obs_to}, {31'd0, e.to});
        chk("retired", obs_ret, e.ret);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit s;
    n_chk = 0; n_pass = 0;
    sel = 1'b0; rst_n = 1'b0; wreq = 1'b0; icls = 3'd0;
    m_lim = 16; m_mask = 32'hFFFF_FFFF; m_ret = 0; m_to = 1'b0;
    @(posedge clk);
    #1;

    // Default configuration: directed sequence, random mix, abort, then fetch timeout.
    push(1, 0, 3'd0, rw(), rc(), 8'h00);
    push(1, 1, 3'd0, rw(), rc(), 8'h00);
    push_instr(0, 0, 0, 1'b0, s);
    push_instr(1, 0, 3, 1'b0, s);
    push_instr(2, 0, 0, 1'b0, s);
    push_instr(4, 0, 0, 1'b0, s);
    push(1, 1, 3'd5, rw(), rc(), 8'h00);
    push_random(30, 3, 3);
    push_instr(0, 9, 0, 1'b0, s);
    push_instr(1, 2, 12, 1'b0, s);
    push_instr(2, 1, 2, 1'b1, s);
    push_random(10, 3, 3);
    push_instr(0, 16, 0, 1'b0, s);
    push(1, 1, 3'd6, rw(), rc(), 8'h00);
    push_instr(0, 0, 0, 1'b0, s);
    run_trace();

    // Small configuration: fetch timeout from reset, counter wrap, random, MEM timeout.
    sel = 1'b1;
    m_lim = 4; m_mask = 32'h0000_000F; m_ret = 0; m_to = 1'b0;
    push(1, 0, 3'd0, rw(), rc(), 8'h00);
    push(1, 1, 3'd0, rw(), rc(), 8'h00);
    push_instr(0, 10, 0, 1'b0, s);
    push(1, 1, 3'd6, rw(), rc(), 8'h00);
    for (int i = 0; i < 17; i++) push_instr(3, 0, 0, 1'b0, s);
    push_random(20, 3, 3);
    push_instr(1, 0, 6, 1'b0, s);
    push(1, 1, 3'd6, rw(), rc(), 8'h00);
    push_instr(3, 0, 0, 1'b0, s);
    run_trace();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
